// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: widths, ALUOp/funct encodings, MUL FSM states.
// Pure declarations, no logic; no latency.
// No flow control; consumed by ex_stage and mul_iter.
package ex_stage_pkg;

    localparam int DATA_LEN   = 32;
    localparam int ALUOP_LEN  = 2;
    localparam int MUL_CYCLES = DATA_LEN;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    localparam logic [ALUOP_LEN-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_LEN-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_LEN-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_LEN-1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRA = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // A forward source matches when it writes, is not x0, and targets rs.
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative shift-add multiplier producing the low DATA_LEN bits of a*b.
// Latency: start accepted in IDLE, MUL_CYCLES steps in BUSY, product valid for one cycle in DONE.
// No backpressure: start_i is ignored outside IDLE; caller stalls upstream while busy.
module mul_iter
    import ex_stage_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DATA_LEN-1:0] a_i,
    input  logic [DATA_LEN-1:0] b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [DATA_LEN-1:0] prod_o
);

    mul_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_LEN-1:0] mcand;
    logic [DATA_LEN-1:0] mplier;
    logic [DATA_LEN-1:0] acc;

    // FSM: latch operands on start, one shift-add step per BUSY cycle, single DONE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start_i) begin
                        mcand  <= a_i;
                        mplier <= b_i;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    assign busy_o = (state == MUL_BUSY);
    assign done_o = (state == MUL_DONE);
    assign prod_o = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative MUL, EX/MEM register.
// Latency: 1 cycle for ALU ops; MUL result lands 34 posedges after it enters.
// Backpressure: Stall_o holds upstream for 33 cycles per MUL while EX/MEM takes bubbles.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 RegWrite_i,
    input  logic                 MemtoReg_i,
    input  logic                 MemWrite_i,
    input  logic                 MemRead_i,
    input  logic [ALUOP_LEN-1:0] ALUOp_i,
    input  logic                 ALUSrc_i,
    input  logic [31:0]          inst_i,
    input  logic [DATA_LEN-1:0]  Imm_i,
    input  logic [DATA_LEN-1:0]  Rd1_i,
    input  logic [DATA_LEN-1:0]  Rd2_i,
    input  logic                 WB_RegWrite_i,
    input  logic [4:0]           WB_Rd_i,
    input  logic [DATA_LEN-1:0]  WB_Data_i,
    output logic                 RegWrite_o,
    output logic                 MemtoReg_o,
    output logic                 MemWrite_o,
    output logic                 MemRead_o,
    output logic [DATA_LEN-1:0]  ALURes_o,
    output logic [DATA_LEN-1:0]  WrData_o,
    output logic [4:0]           Rd_o,
    output logic                 Stall_o
);

    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic                unused_opcode;
    logic [DATA_LEN-1:0] fwd_a;
    logic [DATA_LEN-1:0] fwd_b;
    logic [DATA_LEN-1:0] op_b;
    logic [DATA_LEN-1:0] alu_res;
    logic                is_mul;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [DATA_LEN-1:0] mul_prod;

    assign rd            = inst_i[11:7];
    assign f3            = inst_i[14:12];
    assign rs1           = inst_i[19:15];
    assign rs2           = inst_i[24:20];
    assign f7            = inst_i[31:25];
    assign unused_opcode = ^inst_i[6:0];

    // EX/MEM result beats WB write-back, which beats the register file read.
    assign fwd_a = fwd_hit(RegWrite_o, Rd_o, rs1)       ? ALURes_o  :
                   fwd_hit(WB_RegWrite_i, WB_Rd_i, rs1) ? WB_Data_i : Rd1_i;
    assign fwd_b = fwd_hit(RegWrite_o, Rd_o, rs2)       ? ALURes_o  :
                   fwd_hit(WB_RegWrite_i, WB_Rd_i, rs2) ? WB_Data_i : Rd2_i;
    assign op_b  = ALUSrc_i ? Imm_i : fwd_b;

    assign is_mul = (ALUOp_i == ALUOP_RTYPE) && (f7 == F7_MUL) && (f3 == F3_ADD);

    // A MUL only starts from IDLE, so the instruction still held during DONE is not re-run.
    assign mul_start = is_mul && !mul_busy && !mul_done;
    assign Stall_o   = !rst_i && (mul_start || mul_busy);

    // Single-cycle ALU; unlisted encodings (and MUL, handled separately) give 0.
    always_comb begin
        alu_res = '0;
        case (ALUOp_i)
            ALUOP_ADD: alu_res = fwd_a + op_b;
            ALUOP_SUB: alu_res = fwd_a - op_b;
            ALUOP_RTYPE: begin
                case (f3)
                    F3_ADD: begin
                        if (f7 == F7_BASE) begin
                            alu_res = fwd_a + op_b;
                        end else if (f7 == F7_ALT) begin
                            alu_res = fwd_a - op_b;
                        end
                    end
                    F3_AND:  alu_res = fwd_a & op_b;
                    F3_OR:   alu_res = fwd_a | op_b;
                    F3_XOR:  alu_res = fwd_a ^ op_b;
                    F3_SLL:  alu_res = fwd_a << op_b[4:0];
                    default: alu_res = '0;
                endcase
            end
            ALUOP_ITYPE: begin
                case (f3)
                    F3_ADD:  alu_res = fwd_a + op_b;
                    F3_SRA:  alu_res = $unsigned($signed(fwd_a) >>> Imm_i[4:0]);
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    mul_iter u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_i     (fwd_a),
        .b_i     (op_b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // EX/MEM register: bubble while stalled, product substituted in the DONE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || Stall_o) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            ALURes_o   <= '0;
            WrData_o   <= '0;
            Rd_o       <= '0;
        end else begin
            RegWrite_o <= RegWrite_i;
            MemtoReg_o <= MemtoReg_i;
            MemWrite_o <= MemWrite_i;
            MemRead_o  <= MemRead_i;
            ALURes_o   <= mul_done ? mul_prod : alu_res;
            WrData_o   <= fwd_b;
            Rd_o       <= rd;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model (plain '*' for MUL, cycle countdown for stall).
// Upstream hold is emulated: instruction inputs only change when the previous cycle did not stall.
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i;
    logic [31:0] inst_i, Imm_i, Rd1_i, Rd2_i;
    logic        WB_RegWrite_i;
    logic [4:0]  WB_Rd_i;
    logic [31:0] WB_Data_i;
    logic        RegWrite_o, MemtoReg_o, MemWrite_o, MemRead_o;
    logic [31:0] ALURes_o, WrData_o;
    logic [4:0]  Rd_o;
    logic        Stall_o;

    always #5 clk_i = ~clk_i;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .inst_i(inst_i), .Imm_i(Imm_i),
        .Rd1_i(Rd1_i), .Rd2_i(Rd2_i),
        .WB_RegWrite_i(WB_RegWrite_i), .WB_Rd_i(WB_Rd_i), .WB_Data_i(WB_Data_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
        .ALURes_o(ALURes_o), .WrData_o(WrData_o), .Rd_o(Rd_o), .Stall_o(Stall_o)
    );

    int total = 0;
    int bad   = 0;
    int stall_cnt = 0;
    bit chk_en = 1'b0;
    bit prev_stall = 1'b0;

    // Model of the EX/MEM register and MUL progress.
    logic        exp_rw = 0, exp_m2r = 0, exp_mw = 0, exp_mr = 0, exp_stall = 0;
    logic [31:0] exp_res = 0, exp_wd = 0;
    logic [4:0]  exp_rd = 0;
    int          mul_left = 0;
    bit          mul_done = 0;
    logic [31:0] mul_prod = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("stall",    Stall_o,    exp_stall);
            chk("regwrite", RegWrite_o, exp_rw);
            chk("memtoreg", MemtoReg_o, exp_m2r);
            chk("memwrite", MemWrite_o, exp_mw);
            chk("memread",  MemRead_o,  exp_mr);
            chk("alures",   ALURes_o,   exp_res);
            chk("wrdata",   WrData_o,   exp_wd);
            chk("rd",       Rd_o,       exp_rd);
        end
    end

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rv);
        if (exp_rw && exp_rd != 0 && exp_rd == rs) return exp_res;
        if (WB_RegWrite_i && WB_Rd_i != 0 && WB_Rd_i == rs) return WB_Data_i;
        return rv;
    endfunction

    function automatic bit model_is_mul();
        return ALUOp_i == 2'b10 && inst_i[31:25] == 7'h01 && inst_i[14:12] == 3'b000;
    endfunction

    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b);
        logic [6:0]  f7;
        logic [2:0]  f3;
        int          sh;
        logic [31:0] fill;
        f7 = inst_i[31:25];
        f3 = inst_i[14:12];
        case (ALUOp_i)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: begin
                if (f3 == 3'd0 && f7 == 7'h00) return a + b;
                if (f3 == 3'd0 && f7 == 7'h20) return a - b;
                if (f3 == 3'd7) return a & b;
                if (f3 == 3'd6) return a | b;
                if (f3 == 3'd4) return a ^ b;
                if (f3 == 3'd1) return a << b[4:0];
                return 32'd0;
            end
            default: begin
                if (f3 == 3'd0) return a + b;
                if (f3 == 3'd5) begin
                    sh   = int'(Imm_i[4:0]);
                    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                    return (a >> sh) | fill;
                end
                return 32'd0;
            end
        endcase
    endfunction

    // One clock: predict stall for current inputs, let the compare run, then advance the model.
    task automatic cycle();
        logic [31:0] a, b, wd, n_res, n_prod;
        logic        n_rw, n_m2r, n_mw, n_mr;
        logic [4:0]  n_rd;
        int          n_left;
        bit          n_done, m;
        a  = fwd(inst_i[19:15], Rd1_i);
        wd = fwd(inst_i[24:20], Rd2_i);
        b  = ALUSrc_i ? Imm_i : wd;
        m  = model_is_mul();
        exp_stall = !rst_i && (mul_left > 0 || (!mul_done && m));
        @(negedge clk_i);
        if (Stall_o === 1'b1) stall_cnt++;
        n_rw = 0; n_m2r = 0; n_mw = 0; n_mr = 0; n_res = 0; n_wd_clear: begin end
        n_rd = 0; n_left = mul_left; n_done = mul_done; n_prod = mul_prod;
        begin : advance
            logic [31:0] n_wd;
            n_wd = 0;
            if (rst_i) begin
                n_left = 0; n_done = 0;
            end else if (mul_done) begin
                n_rw = RegWrite_i; n_m2r = MemtoReg_i; n_mw = MemWrite_i; n_mr = MemRead_i;
                n_res = mul_prod; n_wd = wd; n_rd = inst_i[11:7]; n_done = 0;
            end else if (mul_left > 0) begin
                n_left = mul_left - 1;
                n_done = (n_left == 0);
            end else if (m) begin
                n_prod = a * b;
                n_left = 32;
            end else begin
                n_rw = RegWrite_i; n_m2r = MemtoReg_i; n_mw = MemWrite_i; n_mr = MemRead_i;
                n_res = model_alu(a, b); n_wd = wd; n_rd = inst_i[11:7];
            end
            @(posedge clk_i);
            #1;
            exp_rw = n_rw; exp_m2r = n_m2r; exp_mw = n_mw; exp_mr = n_mr;
            exp_res = n_res; exp_wd = n_wd; exp_rd = n_rd;
        end
        mul_left = n_left; mul_done = n_done; mul_prod = n_prod;
        prev_stall = exp_stall;
    endtask

    task automatic set_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] r1, input logic [31:0] r2);
        ALUOp_i = 2'b10; ALUSrc_i = 1'b0; Imm_i = 32'd0;
        RegWrite_i = 1'b1; MemtoReg_i = 1'b0; MemWrite_i = 1'b0; MemRead_i = 1'b0;
        inst_i = {f7, rs2, rs1, f3, rd, 7'b0110011};
        Rd1_i = r1; Rd2_i = r2;
    endtask

    task automatic rand_inst();
        logic [6:0] f7;
        logic [2:0] f3;
        int k;
        ALUOp_i = 2'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'h00;
        if (ALUOp_i == 2'b10) begin
            k = $urandom_range(0, 5);
            if (k < 3) begin
                f3 = 3'd0;
                f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'h01;
            end
        end else if (ALUOp_i == 2'b11) begin
            k = $urandom_range(0, 3);
            if (k == 0) f3 = 3'd0;
            if (k == 1) f3 = 3'd5;
        end
        ALUSrc_i = (ALUOp_i == 2'b11) ? 1'b1 : (ALUOp_i == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
        inst_i = {f7, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), f3,
                  5'($urandom_range(0, 4)), 7'($urandom)};
        Imm_i = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom;
        Rd1_i = $urandom; Rd2_i = $urandom;
        RegWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom);
        MemWrite_i = 1'($urandom); MemRead_i = 1'($urandom);
    endtask

    initial begin
        rst_i = 1'b1;
        WB_RegWrite_i = 1'b0; WB_Rd_i = 5'd0; WB_Data_i = 32'd0;
        set_r(5'd9, 5'd1, 5'd2, 7'h01, 3'd0, 32'd6, 32'd7);
        @(posedge clk_i);
        #1;
        chk_en = 1'b1;
        // Reset held with a MUL presented: outputs 0, no stall.
        cycle();
        cycle();
        chk("rst_alures", ALURes_o, 32'd0);
        chk("rst_stall", Stall_o, 1'b0);

        rst_i = 1'b0;
        set_r(5'd3, 5'd1, 5'd2, 7'h00, 3'd0, 32'd5, 32'd7);
        cycle();
        chk("add_res", ALURes_o, 32'd12);
        chk("add_rd", Rd_o, 5'd3);
        chk("add_rw", RegWrite_o, 1'b1);
        chk("model_add", exp_res, 32'd12);

        set_r(5'd4, 5'd3, 5'd1, 7'h20, 3'd0, 32'd0, 32'd5);
        cycle();
        chk("exmem_fwd", ALURes_o, 32'd7);

        WB_RegWrite_i = 1'b1; WB_Rd_i = 5'd2; WB_Data_i = 32'd100;
        set_r(5'd5, 5'd1, 5'd2, 7'h00, 3'd0, 32'd1, 32'd0);
        cycle();
        chk("wb_fwd", ALURes_o, 32'd101);

        WB_Rd_i = 5'd5; WB_Data_i = 32'd999;
        set_r(5'd6, 5'd5, 5'd0, 7'h00, 3'd0, 32'd0, 32'd50);
        cycle();
        chk("fwd_prio", ALURes_o, 32'd151);

        set_r(5'd0, 5'd1, 5'd2, 7'h00, 3'd0, 32'd3, 32'd4);
        cycle();
        WB_Rd_i = 5'd0; WB_Data_i = 32'd55;
        set_r(5'd8, 5'd0, 5'd0, 7'h00, 3'd0, 32'd0, 32'd0);
        cycle();
        chk("x0_nofwd", ALURes_o, 32'd0);
        WB_RegWrite_i = 1'b0;

        set_r(5'd9, 5'd1, 5'd2, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3);
        stall_cnt = 0;
        repeat (33) cycle();
        chk("mul_stall_cnt", stall_cnt, 33);
        chk("mul_bubble_rw", RegWrite_o, 1'b0);
        cycle();
        chk("mul_res", ALURes_o, 32'hFFFF_FFFD);
        chk("mul_rw", RegWrite_o, 1'b1);
        chk("mul_rd", Rd_o, 5'd9);
        chk("mul_stall_tot", stall_cnt, 33);

        set_r(5'd10, 5'd9, 5'd0, 7'h00, 3'd0, 32'd0, 32'd0);
        cycle();
        chk("mul_fwd", ALURes_o, 32'hFFFF_FFFD);

        set_r(5'd11, 5'd1, 5'd2, 7'h01, 3'd0, 32'd6, 32'd7);
        repeat (11) cycle();
        rst_i = 1'b1;
        cycle();
        chk("abort_res", ALURes_o, 32'd0);
        chk("abort_rd", Rd_o, 5'd0);
        rst_i = 1'b0;
        stall_cnt = 0;
        repeat (34) cycle();
        chk("mul42_res", ALURes_o, 32'd42);
        chk("mul42_stall", stall_cnt, 33);

        for (int i = 0; i < 600; i++) begin
            if (!prev_stall) rand_inst();
            rst_i = ($urandom_range(0, 79) == 0);
            WB_RegWrite_i = 1'($urandom);
            WB_Rd_i = 5'($urandom_range(0, 4));
            WB_Data_i = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
